// File: rtl/axi4_slave_mem_if.sv
// AXI4 bus bundle between a master agent and the slave memory.
// Clock and reset are carried as plain ports beside it.
interface axi4_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);

  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [ID_WIDTH-1:0]     AWID;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;

  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic [ID_WIDTH-1:0]     WID;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;

  logic [ID_WIDTH-1:0]     BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [ID_WIDTH-1:0]     ARID;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARVALID;
  logic                    ARREADY;

  logic [DATA_WIDTH-1:0]   RDATA;
  logic [ID_WIDTH-1:0]     RID;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WID, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARADDR, ARID, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RDATA, RID, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WID, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARID, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RDATA, RID, RRESP, RLAST, RVALID,
    input  RREADY
  );

endinterface

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: independent write and read FSMs over a
// byte-strobed word array, FIXED/INCR/WRAP bursts, OKAY/SLVERR/DECERR.
module axi4_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256
) (
  input logic             ACLK,
  input logic             ARESETn,
  axi4_slave_mem_if.slave bus
);

  localparam int AW  = ADDR_WIDTH;
  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = $clog2(MEM_DEPTH);
  localparam logic [2:0] LSB3 = 3'(LSB);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  function automatic logic in_range(input logic [AW-1:0] a);
    return (a >> (IW + LSB)) == '0;
  endfunction

  function automatic logic [IW-1:0] widx(input logic [AW-1:0] a);
    return a[IW+LSB-1:LSB];
  endfunction

  function automatic logic cfg_err(
    input logic [7:0] len,
    input logic [2:0] size,
    input logic [1:0] burst
  );
    logic wrap_bad;
    wrap_bad = (burst == 2'b10) &&
               !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
    return (burst == 2'b11) || (size > LSB3) || wrap_bad;
  endfunction

  function automatic logic [1:0] resp_code(
    input logic dec,
    input logic slv
  );
    if (dec) return RESP_DECERR;
    if (slv) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  // Reserved burst type 2'b11 falls through to INCR stepping.
  function automatic logic [AW-1:0] next_addr(
    input logic [AW-1:0] a,
    input logic [7:0]    len,
    input logic [2:0]    size,
    input logic [1:0]    burst
  );
    logic [AW-1:0] nb;
    logic [AW-1:0] wsz;
    logic [AW-1:0] inc;
    logic [AW-1:0] bnd;
    nb  = AW'(1) << size;
    wsz = AW'({1'b0, len} + 9'd1) << size;
    inc = (a & ~(nb - AW'(1))) + nb;
    bnd = a & ~(wsz - AW'(1));
    unique case (burst)
      2'b00:   return a;
      2'b10:   return (inc == bnd + wsz) ? bnd : inc;
      default: return inc;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------- write channel state ----------------
  w_state_e            w_state_q, w_state_d;
  logic [AW-1:0]       w_addr_q, w_addr_d;
  logic [ID_WIDTH-1:0] w_id_q, w_id_d;
  logic [7:0]          w_len_q, w_len_d;
  logic [2:0]          w_size_q, w_size_d;
  logic [1:0]          w_burst_q, w_burst_d;
  logic [7:0]          w_cnt_q, w_cnt_d;
  logic                w_dec_q, w_dec_d;
  logic                w_slv_q, w_slv_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d;
  logic                mem_we;
  logic                w_beat_last;
  logic [AW-1:0]       w_nxt;

  assign w_beat_last = (w_cnt_q == w_len_q);
  assign w_nxt = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);

  // Write FSM next-state: capture AW, absorb beats, report worst response.
  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_id_d    = w_id_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    w_dec_d   = w_dec_q;
    w_slv_d   = w_slv_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awready_q && bus.AWVALID) begin
          w_state_d = W_DATA;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_addr_d  = bus.AWADDR;
          w_id_d    = bus.AWID;
          w_len_d   = bus.AWLEN;
          w_size_d  = bus.AWSIZE;
          w_burst_d = bus.AWBURST;
          w_cnt_d   = '0;
          w_dec_d   = 1'b0;
          w_slv_d   = cfg_err(bus.AWLEN, bus.AWSIZE, bus.AWBURST);
        end
      end
      W_DATA: begin
        if (wready_q && bus.WVALID) begin
          if (in_range(w_addr_q)) begin
            mem_we = 1'b1;
          end else begin
            w_dec_d = 1'b1;
          end
          if (bus.WLAST != w_beat_last) begin
            w_slv_d = 1'b1;
          end
          w_addr_d = w_nxt;
          w_cnt_d  = w_cnt_q + 8'd1;
          if (w_beat_last) begin
            w_state_d = W_RESP;
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = w_id_q;
            bresp_d   = resp_code(w_dec_d, w_slv_d);
          end
        end
      end
      W_RESP: begin
        if (bus.BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM registers; reset aborts any burst in flight.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_id_q    <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_dec_q   <= 1'b0;
      w_slv_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      bid_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_id_q    <= w_id_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_dec_q   <= w_dec_d;
      w_slv_q   <= w_slv_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
    end
  end

  // Byte-lane writes; storage is intentionally not reset.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.WSTRB[b]) begin
          mem[widx(w_addr_q)][8*b +: 8] <= bus.WDATA[8*b +: 8];
        end
      end
    end
  end

  // ---------------- read channel state ----------------
  r_state_e              r_state_q, r_state_d;
  logic [AW-1:0]         r_addr_q, r_addr_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic                  r_slv_q, r_slv_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [AW-1:0]         r_nxt;
  logic [AW-1:0]         r_fetch;
  logic                  r_fetch_ok;
  logic [DATA_WIDTH-1:0] r_fetch_data;

  assign r_nxt = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
  assign r_fetch = (r_state_q == R_IDLE) ? bus.ARADDR : r_nxt;
  assign r_fetch_ok = in_range(r_fetch);
  assign r_fetch_data = r_fetch_ok ? mem[widx(r_fetch)] : '0;

  // Read FSM next-state: beat 0 loads on AR, later beats on RREADY.
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    r_slv_d   = r_slv_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    rid_d     = rid_q;
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arready_q && bus.ARVALID) begin
          r_state_d = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          r_addr_d  = bus.ARADDR;
          r_id_d    = bus.ARID;
          r_len_d   = bus.ARLEN;
          r_size_d  = bus.ARSIZE;
          r_burst_d = bus.ARBURST;
          r_cnt_d   = '0;
          r_slv_d   = cfg_err(bus.ARLEN, bus.ARSIZE, bus.ARBURST);
          rid_d     = bus.ARID;
          rlast_d   = (bus.ARLEN == 8'd0);
          rdata_d   = r_fetch_data;
          rresp_d   = resp_code(!r_fetch_ok, r_slv_d);
        end
      end
      R_DATA: begin
        if (bus.RREADY) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            r_addr_d = r_nxt;
            r_cnt_d  = r_cnt_q + 8'd1;
            rlast_d  = (r_cnt_d == r_len_q);
            rdata_d  = r_fetch_data;
            rresp_d  = resp_code(!r_fetch_ok, r_slv_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM registers; all R outputs come straight from flops.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_id_q    <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      r_slv_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      rid_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_id_q    <= r_id_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      r_slv_q   <= r_slv_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      rid_q     <= rid_d;
    end
  end

  // WID carries no information for a single-outstanding slave.
  logic unused_wid;
  assign unused_wid = ^bus.WID;

  assign bus.AWREADY = awready_q;
  assign bus.WREADY  = wready_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.BRESP   = bresp_q;
  assign bus.BID     = bid_q;
  assign bus.ARREADY = arready_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RLAST   = rlast_q;
  assign bus.RRESP   = rresp_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RID     = rid_q;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem: driver pushes expected B/R
// responses into queues, a negedge monitor pops and compares.
module tb_axi4_slave_mem;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int IDW    = 4;
  localparam int DEPTH  = 256;
  localparam int HS_MAX = 20;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  axi4_slave_mem_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW)
  ) bus ();

  axi4_slave_mem #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .ID_WIDTH(IDW), .MEM_DEPTH(DEPTH)
  ) dut (
    .ACLK(clk),
    .ARESETn(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [1:0]     resp;
  } b_t;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [IDW-1:0] id;
    logic [1:0]     resp;
    logic           last;
  } r_t;

  b_t exp_b[$];
  r_t exp_r[$];
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] wd[16];
  logic [DW-1:0] rx[16];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: handshake or response never arrived", name);
  endtask

  // Monitor: compare every completed B and R handshake with the queues.
  always @(negedge clk) begin
    b_t eb;
    r_t er;
    if (rst_n === 1'b1) begin
      if (bus.BVALID && bus.BREADY) begin
        if (exp_b.size() == 0) begin
          fail_now("b_unexpected");
        end else begin
          eb = exp_b.pop_front();
          check("bid", 64'(bus.BID), 64'(eb.id));
          check("bresp", 64'(bus.BRESP), 64'(eb.resp));
        end
      end
      if (bus.RVALID && bus.RREADY) begin
        if (exp_r.size() == 0) begin
          fail_now("r_unexpected");
        end else begin
          er = exp_r.pop_front();
          check("rdata", 64'(bus.RDATA), 64'(er.data));
          check("rid", 64'(bus.RID), 64'(er.id));
          check("rresp", 64'(bus.RRESP), 64'(er.resp));
          check("rlast", 64'(bus.RLAST), 64'(er.last));
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    check({tag, "_ctrl"},
          64'({bus.AWREADY, bus.WREADY, bus.BVALID, bus.BRESP,
               bus.BID, bus.ARREADY, bus.RVALID, bus.RLAST,
               bus.RRESP, bus.RID}), 64'(0));
    check({tag, "_rdata"}, 64'(bus.RDATA), 64'(0));
  endtask

  task automatic aw_send(input logic [AW-1:0] a, input logic [IDW-1:0] id,
                         input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bt);
    int n;
    bus.AWADDR = a;
    bus.AWID = id;
    bus.AWLEN = len;
    bus.AWSIZE = sz;
    bus.AWBURST = bt;
    bus.AWVALID = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.AWREADY && n < HS_MAX) begin
      @(negedge clk);
      n++;
    end
    if (!bus.AWREADY) fail_now("aw_timeout");
    @(posedge clk);
    #1;
    bus.AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [DW-1:0] d,
                        input logic [DW/8-1:0] strb,
                        input logic last);
    int n;
    bus.WDATA = d;
    bus.WSTRB = strb;
    bus.WLAST = last;
    bus.WVALID = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.WREADY && n < HS_MAX) begin
      @(negedge clk);
      n++;
    end
    if (!bus.WREADY) fail_now("w_timeout");
    @(posedge clk);
    #1;
    bus.WVALID = 1'b0;
    bus.WLAST = 1'b0;
  endtask

  task automatic ar_send(input logic [AW-1:0] a, input logic [IDW-1:0] id,
                         input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bt);
    int n;
    bus.ARADDR = a;
    bus.ARID = id;
    bus.ARLEN = len;
    bus.ARSIZE = sz;
    bus.ARBURST = bt;
    bus.ARVALID = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.ARREADY && n < HS_MAX) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ARREADY) fail_now("ar_timeout");
    @(posedge clk);
    #1;
    bus.ARVALID = 1'b0;
  endtask

  task automatic wr_burst(input logic [AW-1:0] a, input logic [IDW-1:0] id,
                          input int len, input logic [2:0] sz,
                          input logic [1:0] bt, input logic [DW/8-1:0] strb,
                          input int lastpos, input logic [1:0] resp);
    b_t e;
    e.id = id;
    e.resp = resp;
    exp_b.push_back(e);
    aw_send(a, id, 8'(len), sz, bt);
    check("wready_after_aw", 64'(bus.WREADY), 64'(1));
    for (int i = 0; i <= len; i++) begin
      w_send(wd[i], strb, i == lastpos);
    end
    check("wready_after_last", 64'(bus.WREADY), 64'(0));
    check("bvalid_after_last", 64'(bus.BVALID), 64'(1));
  endtask

  task automatic rd_burst(input logic [AW-1:0] a, input logic [IDW-1:0] id,
                          input int len, input logic [2:0] sz,
                          input logic [1:0] bt, input logic [1:0] resp);
    r_t e;
    for (int i = 0; i <= len; i++) begin
      e.data = rx[i];
      e.id = id;
      e.resp = resp;
      e.last = (i == len);
      exp_r.push_back(e);
    end
    ar_send(a, id, 8'(len), sz, bt);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_b.size() != 0 || exp_r.size() != 0) begin
      fail_now("drain_timeout");
      exp_b.delete();
      exp_r.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.AWADDR = '0; bus.AWID = '0; bus.AWLEN = '0;
    bus.AWSIZE = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WID = '0;
    bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b1;
    bus.ARADDR = '0; bus.ARID = '0; bus.ARLEN = '0;
    bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");

    // Release just after an edge; READYs rise on the following edge.
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("awready_pre", 64'(bus.AWREADY), 64'(0));
    check("arready_pre", 64'(bus.ARREADY), 64'(0));
    @(negedge clk);
    check("awready_post", 64'(bus.AWREADY), 64'(1));
    check("arready_post", 64'(bus.ARREADY), 64'(1));
    @(posedge clk);
    #1;

    // INCR write then readback.
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    wr_burst(32'h10, 4'd3, 3, 3'd2, 2'b01, 4'hF, 3, 2'b00);
    drain();
    rx[0] = 32'h11; rx[1] = 32'h22; rx[2] = 32'h33; rx[3] = 32'h44;
    rd_burst(32'h10, 4'd4, 3, 3'd2, 2'b01, 2'b00);
    drain();

    // WRAP read over words 12..15 preloaded with their index.
    wd[0] = 32'h0C; wd[1] = 32'h0D; wd[2] = 32'h0E; wd[3] = 32'h0F;
    wr_burst(32'h30, 4'd1, 3, 3'd2, 2'b01, 4'hF, 3, 2'b00);
    drain();
    rx[0] = 32'h0E; rx[1] = 32'h0F; rx[2] = 32'h0C; rx[3] = 32'h0D;
    rd_burst(32'h38, 4'd7, 3, 3'd2, 2'b10, 2'b00);
    drain();

    // Byte strobes over a zeroed word.
    wd[0] = 32'h0;
    wr_burst(32'h80, 4'd2, 0, 3'd2, 2'b01, 4'hF, 0, 2'b00);
    drain();
    wd[0] = 32'hAABBCCDD;
    wr_burst(32'h80, 4'd2, 0, 3'd2, 2'b01, 4'h5, 0, 2'b00);
    drain();
    rx[0] = 32'h00BB00DD;
    rd_burst(32'h80, 4'd2, 0, 3'd2, 2'b01, 2'b00);
    drain();

    // DECERR write leaves aliasing word 0 untouched.
    wd[0] = 32'h12345678;
    wr_burst(32'h0, 4'd9, 0, 3'd2, 2'b01, 4'hF, 0, 2'b00);
    drain();
    wd[0] = 32'hDEADBEEF;
    wr_burst(32'h400, 4'd9, 0, 3'd2, 2'b01, 4'hF, 0, 2'b11);
    drain();
    rx[0] = 32'h12345678;
    rd_burst(32'h0, 4'd9, 0, 3'd2, 2'b01, 2'b00);
    drain();
    rx[0] = 32'h0;
    rd_burst(32'h400, 4'd10, 0, 3'd2, 2'b01, 2'b11);
    drain();

    // Early WLAST on beat 1 of a 4-beat burst.
    wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3; wd[3] = 32'h4;
    wr_burst(32'h40, 4'd11, 3, 3'd2, 2'b01, 4'hF, 1, 2'b10);
    drain();

    // R backpressure mid-burst: beat 1 must hold for 5 cycles.
    rx[0] = 32'h11; rx[1] = 32'h22; rx[2] = 32'h33; rx[3] = 32'h44;
    rd_burst(32'h10, 4'd5, 3, 3'd2, 2'b01, 2'b00);
    @(posedge clk);
    #1 bus.RREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rvalid", 64'(bus.RVALID), 64'(1));
      check("bp_rdata", 64'(bus.RDATA), 64'(32'h22));
      check("bp_rid", 64'(bus.RID), 64'(5));
      check("bp_rlast", 64'(bus.RLAST), 64'(0));
    end
    @(posedge clk);
    #1 bus.RREADY = 1'b1;
    drain();

    // B backpressure: BVALID holds, no new AW accepted.
    bus.BREADY = 1'b0;
    wd[0] = 32'h55;
    wr_burst(32'h50, 4'd12, 0, 3'd2, 2'b01, 4'hF, 0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_bvalid", 64'(bus.BVALID), 64'(1));
      check("bp_awready", 64'(bus.AWREADY), 64'(0));
    end
    @(posedge clk);
    #1 bus.BREADY = 1'b1;
    drain();

    // Reset during beat 2 of an 8-beat write.
    aw_send(32'h60, 4'd2, 8'd7, 3'd2, 2'b01);
    w_send(32'hA0, 4'hF, 1'b0);
    w_send(32'hA1, 4'hF, 1'b0);
    bus.WDATA = 32'hA2;
    bus.WVALID = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_reset("midreset");
    bus.WVALID = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    wd[0] = 32'hB0; wd[1] = 32'hB1;
    wr_burst(32'h90, 4'd6, 1, 3'd2, 2'b01, 4'hF, 1, 2'b00);
    drain();
    rx[0] = 32'hA0; rx[1] = 32'hA1;
    rd_burst(32'h60, 4'd6, 1, 3'd2, 2'b01, 2'b00);
    drain();
    rx[0] = 32'hB0; rx[1] = 32'hB1;
    rd_burst(32'h90, 4'd6, 1, 3'd2, 2'b01, 2'b00);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
